mcpu_core: RTL and testbench

//  Multi-cycle 32-bit MIPS-subset CPU. Top-level DUT of the CPU bench; only clock and reset are external.

---
 rtl/mcpu_core.sv | 238 +++++++++++++++++++++++
 tb/tb_mcpu_core.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_core.sv
`default_nettype none
// mcpu_core: multi-cycle 32-bit MIPS-subset CPU (unified memory, 32x32 regfile, 5-state control FSM).
// Revision: 1.0

module mcpu_reg32 (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);
  always_ff @(posedge clk) begin
    if (clr)     q <= 32'h0;
    else if (en) q <= d;
  end
endmodule

module mcpu_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] q_all [32];

  for (genvar i = 0; i < 32; i++) begin : gen1
    localparam logic [4:0] IDX     = 5'(i);
    localparam bit         IS_ZERO = (i == 0);
    // Only $0 is cleared by reset; it is never written, so it stays zero.
    mcpu_reg32 greg (
      .clk (clk),
      .clr (reset & IS_ZERO),
      .en  (we & (wa == IDX) & ~IS_ZERO),
      .d   (wd),
      .q   (q_all[i])
    );
  end

  assign rd1 = (ra1 == 5'd0) ? 32'h0 : q_all[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'h0 : q_all[ra2];
endmodule

module mcpu_mem #(
  parameter int MEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        we,
  input  logic [31:0] data_addr,
  input  logic [31:0] wd,
  output logic [31:0] rd
);
  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0]   mem [0:MEM_WORDS-1];
  logic [AW-1:0] idx;
  logic          unused_addr;

  // Out-of-range addresses alias by truncating the word index.
  assign idx         = data_addr[AW+1:2];
  assign unused_addr = ^{data_addr[31:AW+2], data_addr[1:0]};
  assign rd          = mem[idx];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wd;
  end
endmodule

module mcpu_core #(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input logic clk,
  input logic reset
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J  = 6'h02, OP_JAL  = 6'h03, OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22, FN_SLT = 6'h2A;

  state_t      state, next_state;
  logic [31:0] pcout, irout, a, b, alu_out, mdr;
  logic [31:0] mem_rdata, data_addr, rd1, rd2, alu_res;
  logic        mem_we, rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] imm_sext, imm_zext;
  logic        is_ralu, is_jr, is_j, is_jal, is_beq, is_bne;
  logic        is_addi, is_xori, is_lw, is_sw, goes_exec;
  logic        unused_shamt;

  assign opcode       = irout[31:26];
  assign rs           = irout[25:21];
  assign rt           = irout[20:16];
  assign rd           = irout[15:11];
  assign funct        = irout[5:0];
  assign imm          = irout[15:0];
  assign imm_sext     = {{16{imm[15]}}, imm};
  assign imm_zext     = {16'h0, imm};
  assign unused_shamt = ^irout[10:6];

  assign is_ralu = (opcode == OP_RTYPE) &&
                   ((funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_SLT));
  assign is_jr   = (opcode == OP_RTYPE) && (funct == FN_JR);
  assign is_j    = (opcode == OP_J);
  assign is_jal  = (opcode == OP_JAL);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_bne  = (opcode == OP_BNE);
  assign is_addi = (opcode == OP_ADDI);
  assign is_xori = (opcode == OP_XORI);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign goes_exec = is_ralu | is_addi | is_xori | is_lw | is_sw | is_beq | is_bne;

  assign data_addr = (state == MEM) ? alu_out : pcout;

  mcpu_mem #(.MEM_WORDS(MEM_WORDS)) memo (
    .clk       (clk),
    .we        (mem_we),
    .data_addr (data_addr),
    .wd        (b),
    .rd        (mem_rdata)
  );

  // Writes are suppressed while reset is high so an aborted instruction leaves no trace.
  mcpu_regfile regf (
    .clk   (clk),
    .reset (reset),
    .ra1   (rs),
    .ra2   (rt),
    .wa    (rf_wa),
    .we    (rf_we & ~reset),
    .wd    (rf_wd),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  always_comb begin
    alu_res = a + b;
    case (funct)
      FN_SUB:  alu_res = a - b;
      FN_SLT:  alu_res = {31'd0, $signed(a) < $signed(b)};
      default: alu_res = a + b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = FETCH;
    mem_we     = 1'b0;
    rf_we      = 1'b0;
    rf_wa      = rt;
    rf_wd      = alu_out;
    case (state)
      FETCH:  next_state = DECODE;
      DECODE: begin
        if (is_jal) begin
          rf_we = 1'b1;
          rf_wa = 5'd31;
          rf_wd = pcout;
        end
        if (goes_exec) next_state = EXEC;
      end
      EXEC: begin
        if (is_lw || is_sw)        next_state = MEM;
        else if (is_beq || is_bne) next_state = FETCH;
        else                       next_state = WB;
      end
      MEM: begin
        if (is_lw) next_state = WB;
        mem_we = is_sw & ~reset;
      end
      WB: begin
        rf_we = 1'b1;
        rf_wa = is_ralu ? rd : rt;
        rf_wd = is_lw ? mdr : alu_out;
      end
      default: next_state = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcout   <= RESET_PC;
      irout   <= 32'h0;
      a       <= 32'h0;
      b       <= 32'h0;
      alu_out <= 32'h0;
      mdr     <= 32'h0;
    end else begin
      case (state)
        FETCH: begin
          irout <= mem_rdata;
          pcout <= pcout + 32'd4;
        end
        DECODE: begin
          a       <= rd1;
          b       <= rd2;
          alu_out <= pcout + {imm_sext[29:0], 2'b00};
          if (is_j || is_jal) pcout <= {pcout[31:28], irout[25:0], 2'b00};
          else if (is_jr)     pcout <= rd1;
        end
        EXEC: begin
          if (is_ralu)                        alu_out <= alu_res;
          else if (is_addi || is_lw || is_sw) alu_out <= a + imm_sext;
          else if (is_xori)                   alu_out <= a ^ imm_zext;
          // alu_out still holds the branch target computed in DECODE.
          if ((is_beq && (a == b)) || (is_bne && (a != b))) pcout <= alu_out;
        end
        MEM: begin
          if (is_lw) mdr <= mem_rdata;
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mcpu_core.sv
`default_nettype none
// tb_mcpu_core: directed and random programs checked against an instruction-level reference model.
module tb_mcpu_core;
  localparam int MEM_WORDS = 4096;
  localparam logic [5:0] OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_XORI = 6'h0E, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22, FN_SLT = 6'h2A;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [31:0] m_reg [32];
  logic [31:0] m_mem [MEM_WORDS];
  logic [31:0] m_pc;
  logic [31:0] prog [$];
  logic [31:0] dut_regs [32];

  mcpu_core #(.MEM_WORDS(MEM_WORDS), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  for (genvar g = 0; g < 32; g++) begin : g_tap
    assign dut_regs[g] = dut.regf.gen1[g].greg.q;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] ej(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  task automatic wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_reg[r] = v;
  endtask

  // Executes one whole instruction architecturally and reports how many cycles it should take.
  task automatic model_step(output int cyc);
    logic [31:0] ins, pc4, rs_v, rt_v, simm, addr;
    logic [5:0]  op, fn;
    logic [4:0]  rt, rd;
    ins  = m_mem[m_pc[13:2]];
    op   = ins[31:26];
    fn   = ins[5:0];
    rt   = ins[20:16];
    rd   = ins[15:11];
    rs_v = m_reg[ins[25:21]];
    rt_v = m_reg[rt];
    simm = {{16{ins[15]}}, ins[15:0]};
    addr = rs_v + simm;
    pc4  = m_pc + 32'd4;
    m_pc = pc4;
    cyc  = 2;
    case (op)
      6'h00: case (fn)
        FN_ADD: begin wr(rd, rs_v + rt_v); cyc = 4; end
        FN_SUB: begin wr(rd, rs_v - rt_v); cyc = 4; end
        FN_SLT: begin wr(rd, ($signed(rs_v) < $signed(rt_v)) ? 32'd1 : 32'd0); cyc = 4; end
        FN_JR:  m_pc = rs_v;
        default: ;
      endcase
      OP_J:    m_pc = {pc4[31:28], ins[25:0], 2'b00};
      OP_JAL:  begin wr(5'd31, pc4); m_pc = {pc4[31:28], ins[25:0], 2'b00}; end
      OP_BEQ:  begin if (rs_v == rt_v) m_pc = pc4 + (simm << 2); cyc = 3; end
      OP_BNE:  begin if (rs_v != rt_v) m_pc = pc4 + (simm << 2); cyc = 3; end
      OP_ADDI: begin wr(rt, addr); cyc = 4; end
      OP_XORI: begin wr(rt, rs_v ^ {16'h0, ins[15:0]}); cyc = 4; end
      OP_LW:   begin wr(rt, m_mem[addr[13:2]]); cyc = 5; end
      OP_SW:   begin m_mem[addr[13:2]] = rt_v; cyc = 4; end
      default: ;
    endcase
  endtask

  task automatic load_prog();
    for (int i = 0; i < MEM_WORDS; i++) m_mem[i] = 32'h0;
    for (int i = 0; i < prog.size(); i++) m_mem[i] = prog[i];
    for (int i = 0; i < 8; i++) m_mem[2048+i] = $urandom;
    for (int i = 0; i < MEM_WORDS; i++) dut.memo.mem[i] = m_mem[i];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_pc = 32'h0;
    m_reg[0] = 32'h0;
    check("rst_pc", dut.pcout, 32'h0);
    check("rst_ir", dut.irout, 32'h0);
  endtask

  task automatic run_steps(input int n, input bit first);
    int cyc;
    logic [31:0] ins_exp;
    for (int s = 0; s < n; s++) begin
      ins_exp = m_mem[m_pc[13:2]];
      model_step(cyc);
      if (first && s == 0) begin
        @(posedge clk); #1;
        check("first_fetch_ir", dut.irout, ins_exp);
        check("first_fetch_pc", dut.pcout, 32'h4);
        cyc = cyc - 1;
      end
      repeat (cyc) @(posedge clk);
      #1;
      check($sformatf("pc@%0d", s), dut.pcout, m_pc);
      check($sformatf("ir@%0d", s), dut.irout, ins_exp);
      check($sformatf("fetch_addr@%0d", s), dut.memo.data_addr, m_pc);
    end
  endtask

  task automatic compare_state(input string tag);
    for (int i = 0; i < 32; i++) check($sformatf("%s_r%0d", tag, i), dut_regs[i], m_reg[i]);
    for (int i = 2048; i < 2056; i++)
      check($sformatf("%s_m%0d", tag, i), dut.memo.mem[i], m_mem[i]);
  endtask

  task automatic gen_random(input int len);
    int sel;
    logic [4:0] ra, rb, rc;
    logic [15:0] dofs;
    prog.delete();
    for (int k = 0; k < len; k++) begin
      sel  = $urandom_range(0, 9);
      ra   = 5'($urandom_range(0, 7));
      rb   = 5'($urandom_range(0, 7));
      rc   = 5'($urandom_range(1, 7));
      dofs = 16'(32'h2000 + 4 * $urandom_range(0, 7));
      case (sel)
        0: prog.push_back(er(ra, rb, rc, FN_ADD));
        1: prog.push_back(er(ra, rb, rc, FN_SUB));
        2: prog.push_back(er(ra, rb, rc, FN_SLT));
        3, 4: prog.push_back(ei(OP_ADDI, ra, rc, 16'($urandom)));
        5: prog.push_back(ei(OP_XORI, ra, rc, 16'($urandom)));
        6: prog.push_back(ei(OP_SW, 5'd0, rb, dofs));
        7: prog.push_back(ei(OP_LW, 5'd0, rc, dofs));
        8: prog.push_back(ei(OP_BEQ, ra, rb, 16'($urandom_range(0, 1))));
        default: prog.push_back(ei(OP_BNE, ra, rb, 16'($urandom_range(0, 1))));
      endcase
    end
    prog.push_back(ej(OP_J, 26'(len)));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    @(posedge clk); #1;

    // Bring every register to a known zero.
    prog.delete();
    for (int r = 1; r < 32; r++) prog.push_back(ei(OP_ADDI, 5'd0, 5'(r), 16'h0));
    prog.push_back(ej(OP_J, 26'd31));
    load_prog(); do_reset(); run_steps(prog.size() + 2, 1'b1); compare_state("clr");

    // ALU, including writes to $0.
    prog = '{ei(OP_ADDI, 0, 6, 16'd5), ei(OP_ADDI, 0, 7, 16'hFFFD), er(6, 7, 6, FN_ADD),
             er(7, 6, 8, FN_SLT), ei(OP_XORI, 6, 9, 16'hFFFF), ei(OP_ADDI, 0, 0, 16'd7),
             er(6, 6, 0, FN_ADD), ej(OP_J, 26'd7)};
    load_prog(); do_reset(); run_steps(prog.size() + 3, 1'b1); compare_state("alu");
    check("alu_r6", dut_regs[6], 32'd2);
    check("alu_slt", dut_regs[8], 32'd1);
    check("alu_xori", dut_regs[9], 32'h0000FFFD);
    check("alu_r0", dut_regs[0], 32'h0);

    // Store then load through the data region.
    prog = '{ei(OP_ADDI, 0, 6, 16'h2000), ei(OP_ADDI, 0, 7, 16'h1234), ei(OP_SW, 6, 7, 16'd4),
             ei(OP_LW, 6, 8, 16'd4), ej(OP_J, 26'd4)};
    load_prog(); do_reset(); run_steps(prog.size() + 2, 1'b1); compare_state("mem");
    check("mem_word", dut.memo.mem[2049], 32'h1234);
    check("mem_lw", dut_regs[8], 32'h1234);

    // Taken beq, untaken bne, then a counted loop.
    prog = '{ei(OP_ADDI, 0, 6, 16'd0), ei(OP_ADDI, 0, 10, 16'd10), ei(OP_BEQ, 0, 0, 16'd1),
             ei(OP_ADDI, 0, 6, 16'd99), ei(OP_BNE, 6, 6, 16'd1), ei(OP_ADDI, 6, 6, 16'd1),
             ei(OP_BNE, 6, 10, 16'hFFFE), ej(OP_J, 26'd7)};
    load_prog(); do_reset(); run_steps(28, 1'b1); compare_state("br");
    check("br_r6", dut_regs[6], 32'd10);
    check("br_pc", dut.pcout, 32'd28);

    // Call / return, then a jump-to-self.
    prog = '{ej(OP_JAL, 26'd3), ei(OP_ADDI, 0, 11, 16'd1), ej(OP_J, 26'd2),
             ei(OP_ADDI, 0, 12, 16'd2), er(31, 0, 0, FN_JR)};
    load_prog(); do_reset(); run_steps(6, 1'b1); compare_state("jmp");
    check("jal_r31", dut_regs[31], 32'd4);
    check("jmp_r11", dut_regs[11], 32'd1);
    for (int k = 0; k < 4; k++) begin
      repeat (2) @(posedge clk);
      #1;
      check("jself_pc", dut.pcout, 32'd8);
    end

    for (int t = 0; t < 4; t++) begin
      gen_random(24);
      load_prog(); do_reset(); run_steps(28, 1'b1); compare_state($sformatf("rnd%0d", t));
    end

    // Reset lands on the write-back edge of a load.
    prog = '{ei(OP_ADDI, 0, 8, 16'h55), ei(OP_ADDI, 0, 6, 16'h2000), ei(OP_ADDI, 0, 7, 16'h1234),
             ei(OP_SW, 6, 7, 16'd4), ei(OP_LW, 6, 8, 16'd4), ej(OP_J, 26'd5)};
    load_prog(); do_reset(); run_steps(4, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("midlw_ir", dut.irout, prog[4]);
    do_reset();
    check("midlw_r8", dut_regs[8], 32'h55);
    compare_state("midlw");
    run_steps(prog.size() + 1, 1'b1);
    check("restart_r8", dut_regs[8], 32'h1234);
    compare_state("restart");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
